// File: rtl/dot_sched_pkg.sv
// Shared types and width helpers for the time-shared dot-product sequencer.
package dot_sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // Index widths never collapse to zero, so degenerate sizes still elaborate.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned row_w(input int unsigned rows);
    return idx_w(rows);
  endfunction

  function automatic int unsigned col_w(input int unsigned cols);
    return idx_w(cols);
  endfunction

  function automatic int unsigned addr_w(input int unsigned rows, input int unsigned cols);
    return idx_w(rows * cols);
  endfunction

endpackage

// File: rtl/dot_mac_scheduler_if.sv
// Stream, weight ROM and FP-core signals of the dot-product sequencer.
interface dot_mac_scheduler_if #(
  parameter int unsigned ROWS = 10,
  parameter int unsigned COLS = 20
);
  localparam int unsigned ADDR_W = dot_sched_pkg::addr_w(ROWS, COLS);

  logic [31:0]       INPUT_AXIS_TDATA;
  logic              INPUT_AXIS_TLAST;
  logic              INPUT_AXIS_TVALID;
  logic              INPUT_AXIS_TREADY;
  logic [31:0]       OUTPUT_AXIS_TDATA;
  logic              OUTPUT_AXIS_TLAST;
  logic              OUTPUT_AXIS_TVALID;
  logic              OUTPUT_AXIS_TREADY;
  logic [ADDR_W-1:0] weight_addr;
  logic [31:0]       weight_rdata;
  logic [31:0]       mul_a;
  logic [31:0]       mul_b;
  logic              mul_valid;
  logic [31:0]       mul_result;
  logic [31:0]       add_a;
  logic [31:0]       add_b;
  logic              add_valid;
  logic [31:0]       add_result;

  modport master (
    input  INPUT_AXIS_TDATA, INPUT_AXIS_TLAST, INPUT_AXIS_TVALID,
    output INPUT_AXIS_TREADY,
    output OUTPUT_AXIS_TDATA, OUTPUT_AXIS_TLAST, OUTPUT_AXIS_TVALID,
    input  OUTPUT_AXIS_TREADY,
    output weight_addr,
    input  weight_rdata,
    output mul_a, mul_b, mul_valid,
    input  mul_result,
    output add_a, add_b, add_valid,
    input  add_result
  );

  modport slave (
    output INPUT_AXIS_TDATA, INPUT_AXIS_TLAST, INPUT_AXIS_TVALID,
    input  INPUT_AXIS_TREADY,
    input  OUTPUT_AXIS_TDATA, OUTPUT_AXIS_TLAST, OUTPUT_AXIS_TVALID,
    output OUTPUT_AXIS_TREADY,
    input  weight_addr,
    output weight_rdata,
    input  mul_a, mul_b, mul_valid,
    output mul_result,
    input  add_a, add_b, add_valid,
    output add_result
  );

endinterface

// File: rtl/dot_delay_line.sv
// Fixed-length tag shift register; the MSB of each word is its valid flag.
module dot_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             pending
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

  // Valid tags still inside the line, excluding the one presented on dout.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < int'(DEPTH) - 1; i++) pending = pending | stage_q[i][WIDTH-1];
  end

endmodule

// File: rtl/dot_mac_scheduler.sv
// Row-interleaved matrix-vector sequencer driving one shared fp32 multiplier and adder.
module dot_mac_scheduler
  import dot_sched_pkg::*;
#(
  parameter int unsigned ROWS    = 10,
  parameter int unsigned COLS    = 20,
  parameter int unsigned MUL_LAT = 6,
  parameter int unsigned ADD_LAT = 8
) (
  input  logic                 aclk,
  input  logic                 rst,
  dot_mac_scheduler_if.master  bus
);

  localparam int unsigned ROW_W  = row_w(ROWS);
  localparam int unsigned COL_W  = col_w(COLS);
  localparam int unsigned ADDR_W = addr_w(ROWS, COLS);
  localparam int unsigned TAG_W  = ROW_W + 1;

  // A row is revisited ROWS+1 cycles later, so its sum must be back by then.
  if (ADD_LAT >= ROWS) begin : g_add_lat_check
    $error("ADD_LAT (%0d) must be less than ROWS (%0d)", ADD_LAT, ROWS);
  end

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q;
  logic [COL_W-1:0]   col_q;
  logic [31:0]        x_q;
  logic [31:0]        acc_q [ROWS];
  logic               mul_valid_q;
  logic [TAG_W-1:0]   mul_tag, add_tag;
  logic               mul_pend, add_pend;
  logic               in_hs, out_hs, last_row, last_col, issue, mul_busy, frame_done;
  logic               unused_tlast;

  assign unused_tlast = bus.INPUT_AXIS_TLAST;
  assign issue        = (state_q == S_ISSUE);
  assign in_hs        = (state_q == S_IDLE) && bus.INPUT_AXIS_TVALID;
  assign out_hs       = (state_q == S_OUT) && bus.OUTPUT_AXIS_TREADY;
  assign last_row     = (row_q == ROW_W'(ROWS - 1));
  assign last_col     = (col_q == COL_W'(COLS - 1));
  assign mul_busy     = mul_pend | mul_tag[TAG_W-1];
  assign frame_done   = out_hs && last_row;

  // Tag for the product: issue cycle + ROM read + multiplier latency.
  dot_delay_line #(.DEPTH(1 + MUL_LAT), .WIDTH(TAG_W)) u_mul_tags (
    .clk     (aclk),
    .rst     (rst),
    .din     ({issue, row_q}),
    .dout    (mul_tag),
    .pending (mul_pend)
  );

  dot_delay_line #(.DEPTH(ADD_LAT), .WIDTH(TAG_W)) u_add_tags (
    .clk     (aclk),
    .rst     (rst),
    .din     (mul_tag),
    .dout    (add_tag),
    .pending (add_pend)
  );

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_hs) state_d = S_ISSUE;
      S_ISSUE: if (last_row) state_d = last_col ? S_DRAIN : S_IDLE;
      // The add line's output stage retires this cycle, so only earlier stages matter.
      S_DRAIN: if (!mul_busy && !add_pend) state_d = S_OUT;
      S_OUT:   if (frame_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.INPUT_AXIS_TREADY  = (state_q == S_IDLE) && !rst;
    bus.OUTPUT_AXIS_TVALID = (state_q == S_OUT);
    bus.OUTPUT_AXIS_TDATA  = FP_ZERO;
    bus.OUTPUT_AXIS_TLAST  = 1'b0;
    bus.weight_addr        = '0;
    if (state_q == S_OUT) begin
      bus.OUTPUT_AXIS_TDATA = acc_q[row_q];
      bus.OUTPUT_AXIS_TLAST = last_row;
    end
    if (issue) bus.weight_addr = ADDR_W'(32'(row_q) * COLS + 32'(col_q));
    bus.mul_valid = mul_valid_q;
    bus.mul_a     = mul_valid_q ? bus.weight_rdata : FP_ZERO;
    bus.mul_b     = mul_valid_q ? x_q : FP_ZERO;
    bus.add_valid = mul_tag[TAG_W-1];
    bus.add_a     = mul_tag[TAG_W-1] ? bus.mul_result : FP_ZERO;
    bus.add_b     = mul_tag[TAG_W-1] ? acc_q[mul_tag[ROW_W-1:0]] : FP_ZERO;
  end

  // row_q doubles as the output word index while in S_OUT.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      x_q         <= FP_ZERO;
      mul_valid_q <= 1'b0;
    end else begin
      mul_valid_q <= issue;
      unique case (state_q)
        S_IDLE: begin
          if (in_hs) begin
            x_q   <= bus.INPUT_AXIS_TDATA;
            row_q <= '0;
          end
        end
        S_ISSUE: begin
          if (last_row) begin
            row_q <= '0;
            if (!last_col) col_q <= col_q + 1'b1;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        S_OUT: begin
          if (out_hs) begin
            if (last_row) begin
              row_q <= '0;
              col_q <= '0;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(ROWS); r++) acc_q[r] <= FP_ZERO;
    end else if (frame_done) begin
      for (int r = 0; r < int'(ROWS); r++) acc_q[r] <= FP_ZERO;
    end else if (add_tag[TAG_W-1]) begin
      acc_q[add_tag[ROW_W-1:0]] <= bus.add_result;
    end
  end

endmodule
